// File: rtl/pc_sequencer_if.sv
// Return-address stack bus between pc_sequencer (master) and the stack (slave).
//   push/pop : one-cycle strobes from the sequencer
//   wdata    : return address written on push
//   rdata    : stack read data, valid the cycle after pop
//   full     : stack full flag
//   empty    : stack empty flag
interface pc_sequencer_if #(
  parameter int AW = 12
);
  logic          push;
  logic          pop;
  logic [AW-1:0] wdata;
  logic [AW-1:0] rdata;
  logic          full;
  logic          empty;

  modport master (output push, pop, wdata, input  rdata, full, empty);
  modport slave  (input  push, pop, wdata, output rdata, full, empty);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter and call/return sequencer; sole driver of the return stack.
// Ports:
//   clk, Reset        : rising-edge clock, async active-high reset
//   en, op, target    : command (NEXT/JUMP/CALL/RET), sampled only in IDLE
//   clr_fault         : leaves FAULT, clears fault/fault_code
//   stk               : return-stack bus (master side)
//   pc                : program counter
//   depth             : outstanding calls, 0..DEPTH
//   busy              : any state other than IDLE
//   fault, fault_code : sticky error, 01 overflow / 10 underflow
// Every output comes straight from a flop.
module pc_sequencer #(
  parameter int              AW           = 12,
  parameter int              DEPTH        = 8,
  parameter logic [AW-1:0]   RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     en,
  input  logic [1:0]               op,
  input  logic [AW-1:0]            target,
  input  logic                     clr_fault,
  pc_sequencer_if.master           stk,
  output logic [AW-1:0]            pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     busy,
  output logic                     fault,
  output logic [1:0]               fault_code
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVER  = 2'b01;
  localparam logic [1:0] FC_UNDER = 2'b10;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CALL_PUSH = 3'd1;
  localparam logic [2:0] S_RET_POP   = 3'd2;
  localparam logic [2:0] S_RET_LOAD  = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    wdata_d = wdata_q;
    depth_d = depth_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    fault_d = fault_q;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          case (op)
            OP_NEXT: pc_d = pc_q + AW'(1);
            OP_JUMP: pc_d = target;
            OP_CALL: begin
              // Either source of "full" faults; the stack must never see an
              // illegal push even if its flag and our count disagree.
              if (stk.full || depth_q >= DEPTH_MAX) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                code_d  = FC_OVER;
              end else begin
                wdata_d = pc_q + AW'(1);
                tgt_d   = target;
                push_d  = 1'b1;
                state_d = S_CALL_PUSH;
              end
            end
            default: begin // OP_RET
              if (stk.empty || depth_q == '0) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                code_d  = FC_UNDER;
              end else begin
                pop_d   = 1'b1;
                state_d = S_RET_POP;
              end
            end
          endcase
        end
      end
      S_CALL_PUSH: begin
        pc_d    = tgt_q;
        depth_d = depth_q + DW'(1);
        state_d = S_IDLE;
      end
      S_RET_POP: state_d = S_RET_LOAD;
      S_RET_LOAD: begin
        // Popped data is presented by the stack during this cycle.
        pc_d    = stk.rdata;
        depth_d = depth_q - DW'(1);
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clr_fault) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      wdata_q <= '0;
      depth_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      wdata_q <= wdata_d;
      depth_q <= depth_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign stk.push   = push_q;
  assign stk.pop    = pop_q;
  assign stk.wdata  = wdata_q;
  assign pc         = pc_q;
  assign depth      = depth_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer with a transaction-level reference model
// (PC value, queue of return addresses, fault flag) and a behavioural stack.
module tb_pc_sequencer;
  localparam int AW = 12;
  localparam int DEPTH = 8;
  localparam logic [1:0] OP_NEXT = 2'b00, OP_JUMP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] target = '0;
  logic          clr_fault = 1'b0;
  logic [AW-1:0] pc;
  logic [3:0]    depth;
  logic          busy, fault;
  logic [1:0]    fault_code;

  pc_sequencer_if #(.AW(AW)) stk_if ();

  pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_VECTOR(12'h000)) dut (
    .clk(clk), .Reset(Reset), .en(en), .op(op), .target(target),
    .clr_fault(clr_fault), .stk(stk_if.master), .pc(pc), .depth(depth),
    .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // behavioural return stack with optional forced flags
  logic [AW-1:0] mem [DEPTH];
  int  sp;
  bit  force_full = 0, force_empty = 0;
  assign stk_if.full  = (sp == DEPTH) || force_full;
  assign stk_if.empty = (sp == 0) || force_empty;
  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sp <= 0;
      stk_if.rdata <= '0;
    end else begin
      if (stk_if.push && sp < DEPTH) begin
        mem[sp] <= stk_if.wdata;
        sp <= sp + 1;
      end else if (stk_if.pop && sp > 0) begin
        stk_if.rdata <= mem[sp-1];
        sp <= sp - 1;
      end
    end
  end

  // reference model
  logic [AW-1:0] pc_m;
  logic [AW-1:0] rq[$];
  bit            flt_m;
  logic [1:0]    code_m;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_m = 12'h000;
    rq.delete();
    flt_m = 0;
    code_m = 2'b00;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, pc, pc_m);
    chk({tag, ".depth"}, depth, rq.size());
    chk({tag, ".busy"}, busy, flt_m);
    chk({tag, ".fault"}, fault, flt_m);
    chk({tag, ".code"}, fault_code, code_m);
  endtask

  // Issue one command from IDLE (or FAULT) and follow it to completion.
  task automatic do_cmd(input logic [1:0] o, input logic [AW-1:0] t, input bit junk);
    logic [AW-1:0] pc0, exp_w;
    int lat, npush, npop, epush, epop;
    bit was_flt;
    pc0 = pc_m; lat = 1; epush = 0; epop = 0; npush = 0; npop = 0; exp_w = '0;
    was_flt = flt_m;
    if (!flt_m) begin
      case (o)
        OP_NEXT: pc_m = pc_m + 1'b1;
        OP_JUMP: pc_m = t;
        OP_CALL: begin
          if (force_full || rq.size() == DEPTH) begin
            flt_m = 1; code_m = 2'b01;
          end else begin
            exp_w = pc_m + 1'b1;
            rq.push_back(exp_w);
            pc_m = t; lat = 2; epush = 1;
          end
        end
        default: begin
          if (force_empty || rq.size() == 0) begin
            flt_m = 1; code_m = 2'b10;
          end else begin
            pc_m = rq.pop_back(); lat = 3; epop = 1;
          end
        end
      endcase
    end
    @(negedge clk);
    en = 1'b1; op = o; target = t;
    clr_fault = was_flt ? 1'b0 : 1'($urandom_range(0, 3) == 0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (stk_if.push) begin
        npush++;
        chk("wdata", stk_if.wdata, exp_w);
      end
      if (stk_if.pop) npop++;
      if (stk_if.push && stk_if.pop) chk("push_and_pop", 1, 0);
      if (c < lat) begin
        chk("busy_mid", busy, 1);
        chk("pc_mid", pc, pc0);
      end
      if (c == 1) begin
        if (junk) begin op = 2'($urandom); target = AW'($urandom); end
        else en = 1'b0;
      end
    end
    en = 1'b0; clr_fault = 1'b0;
    chk("npush", npush, epush);
    chk("npop", npop, epop);
    chk_state("cmd");
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    flt_m = 0; code_m = 2'b00;
    chk_state("clr");
  endtask

  // Reset asserted while a push or pop strobe is high.
  task automatic reset_mid(input logic [1:0] o);
    @(negedge clk);
    en = 1'b1; op = o; target = 12'h5A5;
    @(negedge clk);
    en = 1'b0;
    if (o == OP_CALL) chk("pre_rst_push", stk_if.push, 1);
    else              chk("pre_rst_pop", stk_if.pop, 1);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("rst_push", stk_if.push, 0);
    chk("rst_pop", stk_if.pop, 0);
    chk_state("rst_mid");
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk_state("rst_idle");
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_push", stk_if.push, 0);
    chk("rst_pop", stk_if.pop, 0);
    chk("rst_wdata", stk_if.wdata, 0);
    chk_state("rst");
    Reset = 1'b0;

    repeat (3) do_cmd(OP_NEXT, 12'h000, 0);
    chk("pc_after_3next", pc, 12'h003);
    do_cmd(OP_JUMP, 12'h0FF, 0);
    do_cmd(OP_JUMP, 12'h3A0, 0);
    do_cmd(OP_JUMP, 12'hFFF, 0);
    do_cmd(OP_NEXT, 12'h000, 0);
    chk("pc_wrap", pc, 12'h000);
    do_cmd(OP_JUMP, 12'h010, 0);
    do_cmd(OP_CALL, 12'h200, 0);
    do_cmd(OP_RET, 12'h000, 0);
    chk("pc_ret", pc, 12'h011);

    // nest to capacity, then overflow
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_CALL, AW'($urandom), i[0]);
    do_cmd(OP_CALL, 12'h123, 0);
    do_cmd(OP_JUMP, 12'h456, 0);
    do_cmd(OP_NEXT, 12'h000, 1);
    do_clear();
    chk("depth_kept", depth, DEPTH);
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_RET, 12'h000, i[0]);
    do_cmd(OP_RET, 12'h000, 0);
    do_cmd(OP_CALL, 12'h777, 0);
    do_clear();

    // stack flag disagrees with depth: the fault wins
    force_full = 1;  do_cmd(OP_CALL, 12'h321, 0); force_full = 0;  do_clear();
    do_cmd(OP_CALL, 12'h321, 0);
    force_empty = 1; do_cmd(OP_RET, 12'h000, 0);  force_empty = 0; do_clear();
    do_cmd(OP_RET, 12'h000, 0);

    reset_mid(OP_CALL);
    do_cmd(OP_CALL, 12'h0AB, 0);
    reset_mid(OP_RET);

    for (int i = 0; i < 400; i++) begin
      if (flt_m && $urandom_range(0, 1) == 0) do_clear();
      else begin
        force_full  = ($urandom_range(0, 15) == 0);
        force_empty = ($urandom_range(0, 15) == 0);
        do_cmd(2'($urandom), AW'($urandom), 1'($urandom));
        force_full = 0; force_empty = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and call/return sequencer for the CPU.
- Sits directly upstream of the 8-entry return-address stack and is its only driver.
- Generates single-cycle push/pop strobes and return addresses for the stack, and reloads the PC from popped data.
- Tracks call depth and raises a sticky fault on stack overflow or underflow, so the stack itself never sees an illegal push or pop.

Parameters:
- AW, 12, address width of PC and stack data.
- DEPTH, 8, return-stack capacity in entries; must match the stack instance.
- RESET_VECTOR, 12'h000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  reset, asynchronous, active-high.
- en  in  1  command valid; sampled only when busy=0.
- op  in  2  00 NEXT, 01 JUMP, 10 CALL, 11 RET.
- target  in  AW  jump/call destination.
- clr_fault  in  1  clears a sticky fault, returns FSM to IDLE.
- stk_rdata  in  AW  stack read data, valid the cycle after stk_pop.
- stk_full  in  1  stack full flag.
- stk_empty  in  1  stack empty flag.
- stk_push  out  1  one-cycle push strobe.
- stk_pop  out  1  one-cycle pop strobe.
- stk_wdata  out  AW  return address to push.
- pc  out  AW  current program counter.
- depth  out  $clog2(DEPTH)+1  outstanding calls, 0..DEPTH.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky error flag.
- fault_code  out  2  00 none, 01 overflow, 10 underflow.

Behaviour:
- Reset (asynchronous, any state, including mid-CALL/RET):
  - pc=RESET_VECTOR, depth=0, stk_push=0, stk_pop=0, stk_wdata=0, fault=0, fault_code=00, state=IDLE.
  - Any partially completed push/pop is abandoned.
- States: IDLE, CALL_PUSH, RET_POP, RET_LOAD, FAULT. All outputs are registered.
- IDLE, en=0: pc holds.
- IDLE, en=1:
  - NEXT: pc<=pc+1 mod 2^AW (12'hFFF -> 12'h000, no flag). Latency 1.
  - JUMP: pc<=target. Latency 1.
  - CALL:
    - Overflow check: stk_full=1 or depth==DEPTH -> FAULT, fault_code=01, pc unchanged, no push.
    - Otherwise: stk_wdata<=pc+1 (wrapping), latch target, go to CALL_PUSH.
  - RET:
    - Underflow check: stk_empty=1 or depth==0 -> FAULT, fault_code=10, pc unchanged, no pop.
    - Otherwise: go to RET_POP.
- CALL_PUSH:
  - stk_push=1 for exactly this cycle; stk_wdata stable.
  - At end of cycle: pc<=latched target, depth+1, -> IDLE.
  - Total CALL latency: 2 cycles.
- RET_POP: stk_pop=1 for exactly this cycle, -> RET_LOAD.
- RET_LOAD:
  - pc<=stk_rdata, depth-1, -> IDLE.
  - Total RET latency: 3 cycles.
- FAULT:
  - busy=1, fault=1, commands ignored, no strobes, pc frozen.
  - clr_fault=1 -> IDLE, fault=0, fault_code=00. depth is kept.
- clr_fault in IDLE or any non-FAULT state: ignored.
- Invariants:
  - en while busy=1 is ignored; no command queuing.
  - stk_push and stk_pop are never both high; each is high for at most one cycle per command.
  - depth never exceeds DEPTH and never underflows.
- Flag mismatch: if a stack flag disagrees with depth, the more restrictive condition wins (fault).

Test Plan:
- Reset, then 3x NEXT -> pc=000,001,002,003; busy stays 0; no strobes.
- pc=0FF, JUMP target=3A0 -> pc=3A0 after 1 cycle; pc=FFF, NEXT -> pc=000.
- pc=010, CALL target=200 -> stk_push pulse with stk_wdata=011, pc=200 two cycles later, depth=1. Then RET with stack returning 011 -> single stk_pop pulse, pc=011 three cycles later, depth=0.
- 8 nested CALLs, then a 9th CALL (stk_full=1) -> fault=1, fault_code=01, pc unchanged, no push. clr_fault -> IDLE, depth=8.
- RET at depth=0 / stk_empty=1 -> fault_code=10, no stk_pop. Commands issued during FAULT are ignored.
- Assert Reset during CALL_PUSH and again during RET_POP -> strobes drop immediately, pc=RESET_VECTOR, depth=0, state IDLE.
